// File: rtl/imem_wb_loader.sv
// imem_wb_loader: Wishbone slave that loads and reads back the 512x32 instruction SRAM
// through its port 0, and holds the core in reset (CTRL.HOLD) while the imem is loaded.
// Register map (offsets from BASE_ADDR): 0x000 CTRL, 0x004 STAT, 0x800..0xFFF imem window.
// Optional feature: define IMEM_CHECKSUM_EN to add the read-only CSUM register at 0x008.
// Register writes act on the whole word; byte selects only matter for imem writes.

module imem_wb_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          ADDR_W    = 9
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              mem_csb0,
    output logic              mem_web0,
    output logic [3:0]        mem_wmask0,
    output logic [ADDR_W-1:0] mem_addr0,
    output logic [31:0]       mem_din0,
    input  logic [31:0]       mem_dout0,
    output logic              core_rst_o
);

    localparam int WCNT_W = ADDR_W + 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [WCNT_W-1:0] WCNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        REG,
        MWR,
        MRD1,
        MRD2
    } stateType;

    stateType          state;
    logic              holdReg;
    logic              errFlag;
    logic [WCNT_W-1:0] wordCount;
    logic              hit;
    logic              isImem;
    logic [9:0]        regWord;
    logic [31:0]       regRdata;
    logic              unusedAdrBits;

`ifdef IMEM_CHECKSUM_EN
    logic [31:0]       checksum;
    logic [31:0]       maskedData;

    assign maskedData = wbs_dat_i & {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                                     {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
`endif

    assign hit           = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign isImem        = wbs_adr_i[11];
    assign regWord       = wbs_adr_i[11:2];
    assign core_rst_o    = holdReg;
    assign unusedAdrBits = ^wbs_adr_i[1:0];

    // Register read mux; unmapped offsets below the imem window read as zero
    always_comb begin
        regRdata = 32'h0;
        case (regWord)
            10'd0:   regRdata = {31'h0, holdReg};
            10'd1:   regRdata = 32'(wordCount) | {15'h0, errFlag, 16'h0};
`ifdef IMEM_CHECKSUM_EN
            10'd2:   regRdata = checksum;
`endif
            default: regRdata = 32'h0;
        endcase
    end

    // Transaction FSM: accepts a request only from IDLE with no ack pending, so a strobe
    // still high during the ack cycle is never taken as a second request
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= 32'h0;
            mem_csb0   <= 1'b1;
            mem_web0   <= 1'b1;
            mem_wmask0 <= 4'h0;
            mem_addr0  <= '0;
            mem_din0   <= 32'h0;
            holdReg    <= 1'b1;
            errFlag    <= 1'b0;
            wordCount  <= '0;
`ifdef IMEM_CHECKSUM_EN
            checksum   <= 32'h0;
`endif
        end else begin
            wbs_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit && !wbs_ack_o) begin
                        if (isImem) begin
                            mem_addr0 <= wbs_adr_i[ADDR_W+1:2];
                            if (wbs_we_i) begin
                                mem_wmask0 <= wbs_sel_i;
                                mem_din0   <= wbs_dat_i;
                                state      <= MWR;
                                if (holdReg) begin
                                    mem_csb0 <= 1'b0;
                                    mem_web0 <= 1'b0;
                                    if (wordCount != WCNT_MAX) begin
                                        wordCount <= wordCount + WCNT_ONE;
                                    end
`ifdef IMEM_CHECKSUM_EN
                                    checksum <= checksum + maskedData;
`endif
                                end else begin
                                    errFlag <= 1'b1;
                                end
                            end else begin
                                mem_csb0 <= 1'b0;
                                mem_web0 <= 1'b1;
                                state    <= MRD1;
                            end
                        end else begin
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= regRdata;
                            state     <= REG;
                            if (wbs_we_i && (regWord == 10'd0)) begin
                                holdReg <= wbs_dat_i[0];
                                if (wbs_dat_i[0]) begin
                                    errFlag <= 1'b0;
                                end
                                if (wbs_dat_i[0] && !holdReg) begin
                                    wordCount <= '0;
`ifdef IMEM_CHECKSUM_EN
                                    checksum  <= 32'h0;
`endif
                                end
                            end
                        end
                    end
                end
                REG: begin
                    state <= IDLE;
                end
                MWR: begin
                    mem_csb0  <= 1'b1;
                    mem_web0  <= 1'b1;
                    wbs_ack_o <= 1'b1;
                    state     <= IDLE;
                end
                MRD1: begin
                    mem_csb0 <= 1'b1;
                    state    <= MRD2;
                end
                MRD2: begin
                    wbs_dat_o <= mem_dout0;
                    wbs_ack_o <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_wb_loader.sv
// tb_imem_wb_loader: self-checking bench for imem_wb_loader with a port-0 SRAM model,
// a behavioural register/imem model, directed scenarios and randomized Wishbone traffic.

module tb_imem_wb_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, datW;
    logic        ack;
    logic [31:0] datR;
    logic        memCsb0, memWeb0;
    logic [3:0]  memWmask0;
    logic [8:0]  memAddr0;
    logic [31:0] memDin0, memDout0;
    logic        coreRst;

    imem_wb_loader dut (
        .wb_clk_i   (clock),
        .wb_rst_i   (reset),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (datW),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (datR),
        .mem_csb0   (memCsb0),
        .mem_web0   (memWeb0),
        .mem_wmask0 (memWmask0),
        .mem_addr0  (memAddr0),
        .mem_din0   (memDin0),
        .mem_dout0  (memDout0),
        .core_rst_o (coreRst)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;
    int cycleNo    = 0;

    // Cycle counter: value seen at a falling edge names the cycle after the last rising edge
    always @(posedge clock) cycleNo <= cycleNo + 1;

    // Port-0 SRAM behaviour: write with byte mask, or registered read, when selected
    logic [31:0] sramMem [512];
    always @(posedge clock) begin
        if (!memCsb0) begin
            if (!memWeb0) begin
                for (int b = 0; b < 4; b++) begin
                    if (memWmask0[b]) sramMem[memAddr0][8*b +: 8] <= memDin0[8*b +: 8];
                end
            end else begin
                memDout0 <= sramMem[memAddr0];
            end
        end
    end

    // Reference model state
    logic [31:0] modelMem [512];
    logic        modelHold = 1'b1;
    logic        modelErr  = 1'b0;
    int          modelWcnt = 0;
    logic [31:0] modelCsum = 32'h0;

    // Per-transaction expectations consumed by the compare process
    bit          compareOn   = 1'b0;
    int          expAckAt    = -1;
    int          expCsbLowAt = -1;
    int          expWebLowAt = -1;
    bit          expIsRead   = 1'b0;
    logic [31:0] expData     = 32'h0;
    logic [8:0]  expAddr     = 9'h0;
    logic [3:0]  expMask     = 4'h0;
    logic [31:0] expDin      = 32'h0;
    logic [31:0] lastRead    = 32'h0;
    int          lastLatency = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cycleNo);
        end
    endtask

    function automatic logic [31:0] regModel(input logic [9:0] wordOff);
        case (wordOff)
            10'd0: return {31'h0, modelHold};
            10'd1: return 32'(modelWcnt) | (32'(modelErr) << 16);
            10'd2: begin
`ifdef IMEM_CHECKSUM_EN
                return modelCsum;
`else
                return 32'h0;
`endif
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic updateModel(input logic isWrite, input logic [31:0] address,
                               input logic [31:0] data, input logic [3:0] byteSel);
        logic [31:0] masked;
        if (!isWrite) return;
        if (address[11]) begin
            if (modelHold) begin
                masked = 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (byteSel[b]) begin
                        modelMem[address[10:2]][8*b +: 8] = data[8*b +: 8];
                        masked[8*b +: 8] = data[8*b +: 8];
                    end
                end
                if (modelWcnt < 512) modelWcnt++;
                modelCsum = modelCsum + masked;
            end else begin
                modelErr = 1'b1;
            end
        end else if (address[11:2] == 10'd0) begin
            if (data[0] && !modelHold) begin
                modelWcnt = 0;
                modelCsum = 32'h0;
            end
            if (data[0]) modelErr = 1'b0;
            modelHold = data[0];
        end
    endtask

    // Every falling edge: compare all meaningful DUT outputs against the model's schedule
    always @(negedge clock) begin
        if (compareOn) begin
            checkOutput("ack", 32'(ack), 32'(cycleNo == expAckAt));
            checkOutput("csb0", 32'(memCsb0), 32'(cycleNo != expCsbLowAt));
            checkOutput("web0", 32'(memWeb0), 32'(cycleNo != expWebLowAt));
            checkOutput("coreRst", 32'(coreRst), 32'(modelHold));
            if (cycleNo == expCsbLowAt) checkOutput("addr0", 32'(memAddr0), 32'(expAddr));
            if (cycleNo == expWebLowAt) begin
                checkOutput("wmask0", 32'(memWmask0), 32'(expMask));
                checkOutput("din0", memDin0, expDin);
            end
            if ((cycleNo == expAckAt) && expIsRead) checkOutput("rdata", datR, expData);
        end
    end

    // One in-window Wishbone transaction, launched at a falling edge
    task automatic applyStimulus(input logic isWrite, input logic [31:0] address,
                                 input logic [31:0] data, input logic [3:0] byteSel,
                                 input bit dropEarly);
        int r, lat, waited;
        bit touched, seen;
        r = cycleNo + 1;
        if (address[11]) begin
            lat     = isWrite ? 2 : 3;
            touched = isWrite ? modelHold : 1'b1;
            expData = modelMem[address[10:2]];
        end else begin
            lat     = 1;
            touched = 1'b0;
            expData = regModel(address[11:2]);
        end
        expAckAt    = r + lat - 1;
        expCsbLowAt = touched ? r : -1;
        expWebLowAt = (touched && isWrite) ? r : -1;
        expIsRead   = !isWrite;
        expAddr     = address[10:2];
        expMask     = byteSel;
        expDin      = data;
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = isWrite;
        adr  = address;
        datW = data;
        sel  = byteSel;
        @(posedge clock);
        updateModel(isWrite, address, data, byteSel);
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 12) begin
            @(negedge clock);
            waited++;
            if (dropEarly) begin
                cyc = 1'b0;
                stb = 1'b0;
            end
            if (ack) begin
                seen        = 1'b1;
                lastRead    = datR;
                lastLatency = cycleNo - r + 1;
            end
        end
        if (!seen) checkOutput("ackTimeout", 32'h0, 32'h1);
        @(negedge clock);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    // Strobe an address outside the window for ten cycles; nothing may respond
    task automatic probeOutOfWindow(input logic [31:0] address);
        bit seen;
        expAckAt    = -1;
        expCsbLowAt = -1;
        expWebLowAt = -1;
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = 1'b1;
        adr  = address;
        datW = 32'hDEAD_BEEF;
        sel  = 4'hF;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (ack) seen = 1'b1;
        end
        checkOutput("outOfWindowAck", 32'(seen), 32'h0);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic randomTraffic(input int count);
        int          kind;
        logic [31:0] a, d;
        logic [3:0]  s;
        logic        wr;
        bit          drop;
        for (int n = 0; n < count; n++) begin
            kind = $urandom_range(0, 99);
            d    = $urandom;
            s    = 4'($urandom);
            wr   = 1'($urandom_range(0, 1));
            drop = ($urandom_range(0, 9) == 0);
            if (kind < 60) begin
                a = BASE + 32'h800 + 32'($urandom_range(0, 2047));
            end else if (kind < 72) begin
                a    = BASE + 32'($urandom_range(0, 3));
                wr   = 1'b1;
                d[0] = ($urandom_range(0, 3) != 0);
            end else if (kind < 82) begin
                a = BASE + 32'h4;
            end else if (kind < 88) begin
                a = BASE + 32'h8;
            end else if (kind < 93) begin
                a  = BASE;
                wr = 1'b0;
            end else begin
                a = BASE + 32'($urandom_range(12, 2047));
            end
            applyStimulus(wr, a, d, s, drop);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
    endtask

    // Safety net against a hung run
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        bit seen;
        reset = 1'b1;
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        sel   = 4'h0;
        adr   = 32'h0;
        datW  = 32'h0;
        for (int i = 0; i < 512; i++) modelMem[i] = 32'h0;

        repeat (3) @(negedge clock);
        checkOutput("resetCoreRst", 32'(coreRst), 32'h1);
        checkOutput("resetCsb0", 32'(memCsb0), 32'h1);
        checkOutput("resetWeb0", 32'(memWeb0), 32'h1);
        checkOutput("resetAck", 32'(ack), 32'h0);
        reset     = 1'b0;
        compareOn = 1'b1;

        $display("[TB] reset register values");
        applyStimulus(1'b0, BASE, 32'h0, 4'hF, 1'b0);
        checkOutput("ctrlAfterReset", lastRead, 32'h1);
        applyStimulus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b0);
        checkOutput("statAfterReset", lastRead, 32'h0);

        $display("[TB] single imem write and readback");
        applyStimulus(1'b1, BASE + 32'h800, 32'h0000_0013, 4'hF, 1'b0);
        checkOutput("writeLatency", 32'(lastLatency), 32'd2);
        applyStimulus(1'b0, BASE + 32'h800, 32'h0, 4'hF, 1'b0);
        checkOutput("readbackData", lastRead, 32'h0000_0013);
        checkOutput("readLatency", 32'(lastLatency), 32'd3);

        $display("[TB] fill all 512 words and saturate WCNT");
        for (int i = 0; i < 512; i++) begin
            applyStimulus(1'b1, BASE + 32'h800 + 32'(i * 4), $urandom, 4'hF, 1'b0);
        end
        applyStimulus(1'b1, BASE + 32'h800, $urandom, 4'hF, 1'b0);
        applyStimulus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b0);
        checkOutput("wcntSaturated", lastRead, 32'h0000_0200);
        applyStimulus(1'b1, BASE, 32'h0, 4'hF, 1'b0);
        checkOutput("coreReleased", 32'(coreRst), 32'h0);

        $display("[TB] imem write while core running");
        applyStimulus(1'b1, BASE + 32'hFFC, 32'h1234_5678, 4'hF, 1'b0);
        applyStimulus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b0);
        checkOutput("errSet", lastRead, 32'h0001_0200);
        applyStimulus(1'b1, BASE, 32'h1, 4'hF, 1'b0);
        applyStimulus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b0);
        checkOutput("errAndWcntCleared", lastRead, 32'h0);

        $display("[TB] partial byte write");
        applyStimulus(1'b1, BASE + 32'h800 + 32'h14, 32'h0, 4'hF, 1'b0);
        applyStimulus(1'b1, BASE + 32'h800 + 32'h14, 32'hAABB_CCDD, 4'b0100, 1'b0);
        applyStimulus(1'b0, BASE + 32'h800 + 32'h14, 32'h0, 4'hF, 1'b0);
        checkOutput("maskedWord", lastRead, 32'h00BB_0000);
        applyStimulus(1'b0, BASE + 32'h8, 32'h0, 4'hF, 1'b0);
`ifdef IMEM_CHECKSUM_EN
        checkOutput("csumValue", lastRead, 32'h00BB_0000);
`else
        checkOutput("csumAbsent", lastRead, 32'h0);
`endif
        applyStimulus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b0);
        checkOutput("wcntTwo", lastRead, 32'h2);

        $display("[TB] randomized traffic");
        randomTraffic(300);

        $display("[TB] reset during a read");
        applyStimulus(1'b1, BASE, 32'h0, 4'hF, 1'b0);
        applyStimulus(1'b1, BASE + 32'h800 + 32'h1C, 32'h5555_AAAA, 4'h3, 1'b0);
        compareOn = 1'b0;
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = 1'b0;
        adr  = BASE + 32'h800 + 32'h1C;
        sel  = 4'hF;
        @(posedge clock);
        @(negedge clock);
        checkOutput("readCsbLow", 32'(memCsb0), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("rstAck", 32'(ack), 32'h0);
        checkOutput("rstCsb0", 32'(memCsb0), 32'h1);
        checkOutput("rstWeb0", 32'(memWeb0), 32'h1);
        checkOutput("rstWmask0", 32'(memWmask0), 32'h0);
        checkOutput("rstAddr0", 32'(memAddr0), 32'h0);
        checkOutput("rstDin0", memDin0, 32'h0);
        checkOutput("rstDatO", datR, 32'h0);
        checkOutput("rstCoreRst", 32'(coreRst), 32'h1);
        cyc  = 1'b0;
        stb  = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (ack) seen = 1'b1;
        end
        checkOutput("ackAfterReset", 32'(seen), 32'h0);
        reset       = 1'b0;
        modelHold   = 1'b1;
        modelErr    = 1'b0;
        modelWcnt   = 0;
        modelCsum   = 32'h0;
        expAckAt    = -1;
        expCsbLowAt = -1;
        expWebLowAt = -1;
        compareOn   = 1'b1;

        $display("[TB] out-of-window access");
        probeOutOfWindow(32'h2000_0000);
        @(negedge clock);
        applyStimulus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b0);
        checkOutput("statAfterOutOfWindow", lastRead, 32'h0);
        applyStimulus(1'b0, BASE + 32'h800 + 32'h1C, 32'h0, 4'hF, 1'b0);

        randomTraffic(100);

        compareOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
